// File: rtl/python_calib_pkg.sv
// Shared state encoding and per-state reset bundles for the PYTHON LVDS
// receive-path calibration sequencer.
package python_calib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_ISERDES_RST   = 3'd1,
        ST_ALIGN_RST     = 3'd2,
        ST_WAIT_CALIB    = 3'd3,
        ST_DPHY_SYS_RST  = 3'd4,
        ST_DPHY_CORE_RST = 3'd5,
        ST_RUN           = 3'd6,
        ST_FAIL          = 3'd7
    } state_t;

    // Reset bundles are ordered {iserdes, align, dphy_sys, dphy_core}.
    localparam logic [3:0] RST_ALL       = 4'b1111;
    localparam logic [3:0] RST_ALIGN_UP  = 4'b0111;
    localparam logic [3:0] RST_DPHY_ONLY = 4'b0011;
    localparam logic [3:0] RST_CORE_ONLY = 4'b0001;
    localparam logic [3:0] RST_NONE      = 4'b0000;

    function automatic logic [3:0] state_resets(input state_t st);
        logic [3:0] r;
        case (st)
            ST_IDLE, ST_ISERDES_RST:           r = RST_ALL;
            ST_ALIGN_RST:                      r = RST_ALIGN_UP;
            ST_WAIT_CALIB, ST_DPHY_SYS_RST:    r = RST_DPHY_ONLY;
            ST_DPHY_CORE_RST:                  r = RST_CORE_ONLY;
            ST_RUN:                            r = RST_NONE;
            ST_FAIL:                           r = RST_DPHY_ONLY;
            default:                           r = RST_ALL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/python_calib_sync.sv
// Multi-bit two-flop synchronizer; each bit is an independent level, so no
// cross-bit coherency is implied.
module python_calib_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/python_calib_sequencer.sv
// Bring-up sequencer for the PYTHON LVDS receive path: orders ISERDES/aligner
// resets, retries calibration, then releases the D-PHY resets.
module python_calib_sequencer
    import python_calib_pkg::*;
#(
    parameter int ISERDES_RESET_CYCLES = 16,
    parameter int ALIGN_RESET_CYCLES   = 64,
    parameter int CALIB_TIMEOUT_CYCLES = 1000000,
    parameter int DPHY_RESET_CYCLES    = 256,
    parameter int MAX_RETRY            = 3,
    parameter int COUNTER_BITS         = 24
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       start,
    input  logic       abort,
    input  logic       in_calib_done,
    input  logic       in_calib_error,
    output logic       out_iserdes_reset,
    output logic       out_align_reset,
    output logic       out_dphy_sys_reset,
    output logic       out_dphy_core_reset,
    output logic       out_busy,
    output logic       out_ready,
    output logic       out_error,
    output logic       out_lost,
    output logic [3:0] out_retry_count,
    output logic [2:0] out_state
);

    localparam logic [COUNTER_BITS-1:0] ISR_LOAD  = COUNTER_BITS'(ISERDES_RESET_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] ALN_LOAD  = COUNTER_BITS'(ALIGN_RESET_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] CAL_LOAD  = COUNTER_BITS'(CALIB_TIMEOUT_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] DPHY_LOAD = COUNTER_BITS'(DPHY_RESET_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] CNT_ONE   = COUNTER_BITS'(1);
    localparam logic [3:0]              RETRY_MAX = 4'(MAX_RETRY);

    state_t                  state_q, state_d;
    logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]              retry_q, retry_d;
    logic                    lost_q, lost_d;
    logic [3:0]              resets_q;
    logic                    busy_q, ready_q, error_q;
    logic                    fail_attempt;
    logic [1:0]              calib_s;
    logic                    done_s, error_s;

    python_calib_sync #(
        .WIDTH (2)
    ) u_sync (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .d_i    ({in_calib_error, in_calib_done}),
        .q_o    (calib_s)
    );

    assign error_s = calib_s[1];
    assign done_s  = calib_s[0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
        retry_d      = retry_q;
        lost_d       = lost_q;
        fail_attempt = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            lost_d  = 1'b0;
        end else if (start) begin
            state_d = ST_ISERDES_RST;
            cnt_d   = ISR_LOAD;
            retry_d = '0;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ISERDES_RST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ALIGN_RST;
                        cnt_d   = ALN_LOAD;
                    end
                end
                ST_ALIGN_RST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_WAIT_CALIB;
                        cnt_d   = CAL_LOAD;
                    end
                end
                ST_WAIT_CALIB: begin
                    // A result seen on the final timeout cycle still counts.
                    if (error_s || (cnt_q == '0 && !done_s)) begin
                        fail_attempt = 1'b1;
                    end else if (done_s) begin
                        state_d = ST_DPHY_SYS_RST;
                        cnt_d   = DPHY_LOAD;
                    end
                end
                ST_DPHY_SYS_RST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DPHY_CORE_RST;
                        cnt_d   = DPHY_LOAD;
                    end
                end
                ST_DPHY_CORE_RST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!done_s || error_s) begin
                        state_d = ST_FAIL;
                        lost_d  = 1'b1;
                    end
                end
                default: ;
            endcase

            if (fail_attempt) begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 4'd1;
                    state_d = ST_ISERDES_RST;
                    cnt_d   = ISR_LOAD;
                end else begin
                    state_d = ST_FAIL;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they switch with out_state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            lost_q   <= 1'b0;
            resets_q <= RST_ALL;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            lost_q   <= lost_d;
            resets_q <= state_resets(state_d);
            busy_q   <= (state_d inside {ST_ISERDES_RST, ST_ALIGN_RST, ST_WAIT_CALIB,
                                         ST_DPHY_SYS_RST, ST_DPHY_CORE_RST});
            ready_q  <= (state_d == ST_RUN);
            error_q  <= (state_d == ST_FAIL);
        end
    end

    assign out_iserdes_reset   = resets_q[3];
    assign out_align_reset     = resets_q[2];
    assign out_dphy_sys_reset  = resets_q[1];
    assign out_dphy_core_reset = resets_q[0];
    assign out_busy            = busy_q;
    assign out_ready           = ready_q;
    assign out_error           = error_q;
    assign out_lost            = lost_q;
    assign out_retry_count     = retry_q;
    assign out_state           = state_q;

endmodule
